mem_loader: RTL and testbench
=============================

MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the target memories; memory depth is 2**ADDR_W words.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 s_valid  input  1  byte-stream valid from host link.
REQ-005 s_data  input  8  byte-stream payload.
REQ-006 s_ready  output  1  loader accepts a byte when s_valid && s_ready.
REQ-007 imem_we  output  1  one-cycle write strobe to instruction memory.
REQ-008 dmem_we  output  1  one-cycle write strobe to data memory.
REQ-009 waddr  output  ADDR_W  word address for the current write.
REQ-010 wdata  output  32  word for the current write.
REQ-011 cpu_hold  output  1  high while a load is in progress; holds the CPU in reset.
REQ-012 done  output  1  one-cycle pulse on successful load.
REQ-013 err  output  1  one-cycle pulse on a rejected load.

Function
REQ-014 Frame format SHALL be: LEN_LO, LEN_HI (16-bit word count N, little-endian), SEL (0x00=imem, 0x01=dmem), 4*N data bytes (each word little-endian), CSUM.
REQ-015 FSM states SHALL be IDLE, LEN_LO, LEN_HI, SEL, DATA, CSUM, STATUS; IDLE is the reset state, and the first accepted byte is LEN_LO.
REQ-016 s_ready SHALL be 1 in every state except STATUS, where it is 0.
REQ-017 Accepting a byte in IDLE SHALL latch LEN_LO, assert cpu_hold on the next cycle, and move to LEN_HI.
REQ-018 After LEN_HI, N > 2**ADDR_W SHALL go to STATUS with err; otherwise the FSM goes to SEL.
REQ-019 A SEL byte other than 0x00 or 0x01 SHALL go to STATUS with err.
REQ-020 After a valid SEL, the FSM SHALL go to DATA if N > 0, else to CSUM.
REQ-021 In DATA, a 2-bit byte counter SHALL assemble the word; byte k fills wdata[8k+7:8k].
REQ-022 The cycle after the 4th byte is accepted, exactly one of imem_we or dmem_we (per SEL) SHALL be high for one cycle, with waddr equal to the word index (0 for the first word) and wdata complete.
REQ-023 After word N-1 is accepted, the FSM SHALL go to CSUM; the write strobe for that word still fires.
REQ-024 The checksum SHALL be an 8-bit XOR of every byte from LEN_LO through the last data byte.
REQ-025 In CSUM, a received byte equal to the running XOR SHALL give done, otherwise err; the FSM goes to STATUS in both cases.
REQ-026 STATUS SHALL last one cycle, pulse done or err, deassert cpu_hold at its end, and return to IDLE.
REQ-027 A stalled stream (s_valid low) SHALL freeze all counters and assembly with no timeout, and no write strobe fires.
REQ-028 Memory writes already issued are not rolled back on a checksum err.
REQ-029 done and err SHALL never be high together.

Reset
REQ-030 Asserting reset SHALL asynchronously force IDLE, s_ready=1, imem_we=dmem_we=0, waddr=0, wdata=0, cpu_hold=0, done=err=0, and clear the checksum and all counters.
REQ-031 Reset in mid-frame SHALL abandon the frame with no further write strobes; the next accepted byte is treated as LEN_LO.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, SEL codes SEL_IMEM=0x00 and SEL_DMEM=0x01, and the header length constant.
REQ-033 One sub-module, byte_to_word (32-bit little-endian assembler with a byte counter and word_valid pulse), SHALL be instantiated; all else is inline.

Verification
REQ-034 Frame 01 00 00 78 56 34 12 CSUM=0x01^0x78^0x56^0x34^0x12 -> imem_we at waddr=0, wdata=0x12345678, then done pulse, cpu_hold low after.
REQ-035 Frame N=3, SEL=01, words 0x11111111/0x22222222/0x33333333 with s_valid toggling every other cycle -> dmem_we at waddr 0,1,2 with matching data, done.
REQ-036 Frame N=0, SEL=00, CSUM=0x00 -> no write strobes, done.
REQ-037 ADDR_W=10, LEN=0x0401 -> err after LEN_HI with no strobes; bad SEL=0x02 -> err; wrong CSUM on a 1-word frame -> one strobe, then err.
REQ-038 Reset asserted after the 2nd data byte of word 1 -> outputs at reset values immediately, no strobe; a following full valid frame loads correctly.

Source files
------------

// File: rtl/mem_loader_pkg.sv
// Shared definitions for the host-link memory loader: FSM encoding, target
// select codes and frame header length.
package mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_SEL,
    ST_DATA,
    ST_CSUM,
    ST_STATUS
  } state_e;

  localparam logic [7:0] SEL_IMEM = 8'h00;
  localparam logic [7:0] SEL_DMEM = 8'h01;

  // LEN_LO, LEN_HI, SEL
  localparam int unsigned HDR_LEN = 3;

endpackage

// File: rtl/mem_loader_byte_to_word.sv
// Little-endian 32-bit word assembler: byte k of a word lands in bits
// [8k+7:8k]; word_valid pulses the cycle after the 4th byte.
module byte_to_word (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [1:0]  cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word       <= 32'h0;
      word_valid <= 1'b0;
      cnt        <= 2'd0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        cnt <= 2'd0;
      end else if (in_valid) begin
        word[{cnt, 3'b000} +: 8] <= in_data;
        cnt                      <= cnt + 2'd1;
        word_valid               <= (cnt == 2'd3);
      end
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Byte-stream boot loader: parses a length/select/data/checksum frame from the
// host link and writes words into instruction or data memory.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_e      state, state_nx;
  logic        done_nx, err_nx;
  logic [15:0] len;
  logic [15:0] wcnt;
  logic [7:0]  csum;
  logic        sel_q;
  logic [1:0]  bcnt;
  logic        word_valid;
  logic        acc;
  logic [16:0] len_req;
  logic        last_word;

  assign acc       = s_valid && s_ready;
  assign len_req   = {1'b0, s_data, len[7:0]};
  assign last_word = (wcnt == len - 16'd1);

  byte_to_word u_b2w (
    .clk        (clk),
    .reset      (reset),
    .clr        (acc && (state == ST_IDLE)),
    .in_valid   (acc && (state == ST_DATA)),
    .in_data    (s_data),
    .word       (wdata),
    .word_valid (word_valid),
    .cnt        (bcnt)
  );

  // State and status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      s_ready  <= 1'b1;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      s_ready  <= (state_nx != ST_STATUS);
      cpu_hold <= (state_nx != ST_IDLE);
      done     <= done_nx;
      err      <= err_nx;
    end
  end

  // Next-state and status decode
  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      ST_IDLE, ST_LEN_LO: begin
        if (acc) state_nx = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (acc) begin
          if (len_req > 17'(DEPTH)) begin
            state_nx = ST_STATUS;
            err_nx   = 1'b1;
          end else begin
            state_nx = ST_SEL;
          end
        end
      end
      ST_SEL: begin
        if (acc) begin
          if (s_data == SEL_IMEM || s_data == SEL_DMEM) begin
            state_nx = (len == 16'd0) ? ST_CSUM : ST_DATA;
          end else begin
            state_nx = ST_STATUS;
            err_nx   = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (acc && bcnt == 2'd3 && last_word) state_nx = ST_CSUM;
      end
      ST_CSUM: begin
        if (acc) begin
          state_nx = ST_STATUS;
          done_nx  = (s_data == csum);
          err_nx   = (s_data != csum);
        end
      end
      ST_STATUS: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Frame datapath: length, select, checksum, word count, write strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len     <= 16'h0;
      wcnt    <= 16'h0;
      csum    <= 8'h0;
      sel_q   <= 1'b0;
      waddr   <= '0;
      imem_we <= 1'b0;
      dmem_we <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      dmem_we <= 1'b0;
      if (word_valid) waddr <= waddr + ADDR_W'(1);
      if (acc) begin
        case (state)
          ST_IDLE, ST_LEN_LO: begin
            len[7:0] <= s_data;
            csum     <= s_data;
            wcnt     <= 16'h0;
            waddr    <= '0;
          end
          ST_LEN_HI: begin
            len[15:8] <= s_data;
            csum      <= csum ^ s_data;
          end
          ST_SEL: begin
            sel_q <= s_data[0];
            csum  <= csum ^ s_data;
          end
          ST_DATA: begin
            csum <= csum ^ s_data;
            if (bcnt == 2'd3) begin
              wcnt    <= wcnt + 16'd1;
              imem_we <= ~sel_q;
              dmem_we <= sel_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: framed loads, error frames and mid-frame reset.
module tb_mem_loader;
  import mem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready, imem_we, dmem_we, cpu_hold, done, err;
  logic [9:0]  waddr;
  logic [31:0] wdata;

  typedef struct {
    bit          d;
    logic [9:0]  a;
    logic [31:0] w;
  } wr_t;

  wr_t wq[$];
  int  checks = 0;
  int  errors = 0;
  int  n_done = 0;
  int  n_err  = 0;
  int  d0, e0;
  logic [7:0] fr[$];

  always #5 clk = ~clk;

  mem_loader #(.ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .imem_we(imem_we), .dmem_we(dmem_we),
    .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold),
    .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Write/status monitor sampled away from the active edge
  always @(negedge clk) begin
    if (imem_we || dmem_we) wq.push_back('{d: dmem_we, a: waddr, w: wdata});
    if (done) n_done++;
    if (err)  n_err++;
    if (done || err) chk("done_err_excl", 32'(done & err), 32'h0);
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (s_ready !== 1'b1 && n < 8) begin
      s_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    if (s_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL s_ready_timeout got %b exp 1", s_ready);
    end
    s_valid = 1'b1;
    s_data  = b;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] f[$], input bit gap);
    foreach (f[i]) begin
      send(f[i]);
      if (gap) @(negedge clk);
    end
  endtask

  task automatic end_frame();
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"},  32'(s_ready),  32'h1);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'h0);
    chk({tag, "_we"},       32'({imem_we, dmem_we}), 32'h0);
    chk({tag, "_waddr"},    32'(waddr),    32'h0);
    chk({tag, "_wdata"},    wdata,         32'h0);
    chk({tag, "_done_err"}, 32'({done, err}), 32'h0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    reset   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b1;
    @(negedge clk);

    // One imem word, step by step
    wq.delete();
    d0 = n_done;
    send(8'h01);
    chk("t1_hold_after_lenlo", 32'(cpu_hold), 32'h1);
    send(8'h00); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34);
    chk("t1_no_early_we", 32'({imem_we, dmem_we}), 32'h0);
    send(8'h12);
    chk("t1_imem_we", 32'({imem_we, dmem_we}), 32'h2);
    chk("t1_waddr", 32'(waddr), 32'h0);
    chk("t1_wdata", wdata, 32'h12345678);
    send(8'h09);
    chk("t1_done", 32'({done, err}), 32'h2);
    chk("t1_status_ready", 32'(s_ready), 32'h0);
    chk("t1_status_hold", 32'(cpu_hold), 32'h1);
    @(negedge clk);
    chk("t1_after_done", 32'(done), 32'h0);
    chk("t1_hold_released", 32'(cpu_hold), 32'h0);
    chk("t1_ready_back", 32'(s_ready), 32'h1);
    chk("t1_done_cnt", 32'(n_done - d0), 32'h1);
    chk("t1_wr_cnt", 32'(wq.size()), 32'h1);

    // Three dmem words with s_valid toggling
    wq.delete(); d0 = n_done; e0 = n_err;
    fr = '{8'h03, 8'h00, 8'h01,
           8'h11, 8'h11, 8'h11, 8'h11,
           8'h22, 8'h22, 8'h22, 8'h22,
           8'h33, 8'h33, 8'h33, 8'h33, 8'h02};
    send_list(fr, 1'b1);
    end_frame();
    chk("t2_wr_cnt", 32'(wq.size()), 32'h3);
    for (int i = 0; i < 3 && i < wq.size(); i++) begin
      chk("t2_sel", 32'(wq[i].d), 32'h1);
      chk("t2_waddr", 32'(wq[i].a), 32'(i));
      chk("t2_wdata", wq[i].w, 32'h11111111 * 32'(i + 1));
    end
    chk("t2_done_cnt", 32'(n_done - d0), 32'h1);
    chk("t2_err_cnt", 32'(n_err - e0), 32'h0);

    // Empty frame: header of zeros, checksum zero
    wq.delete(); d0 = n_done;
    repeat (HDR_LEN) send(8'h00);
    send(8'h00);
    end_frame();
    chk("t3_wr_cnt", 32'(wq.size()), 32'h0);
    chk("t3_done_cnt", 32'(n_done - d0), 32'h1);

    // Length 1025 exceeds 1024-word memory
    wq.delete(); e0 = n_err;
    send(8'h01); send(8'h04);
    chk("t4_err", 32'({done, err}), 32'h1);
    chk("t4_ready", 32'(s_ready), 32'h0);
    end_frame();
    chk("t4_wr_cnt", 32'(wq.size()), 32'h0);
    chk("t4_err_cnt", 32'(n_err - e0), 32'h1);

    // Length 1024 accepted, bad select 0x02 rejected
    e0 = n_err;
    send(8'h00); send(8'h04);
    chk("t5_len1024_ok", 32'(err), 32'h0);
    send(8'h02);
    chk("t5_bad_sel_err", 32'({done, err}), 32'h1);
    end_frame();
    chk("t5_err_cnt", 32'(n_err - e0), 32'h1);

    // Wrong checksum on one word: write stays, err reported
    wq.delete(); d0 = n_done; e0 = n_err;
    fr = '{8'h01, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h02};
    send_list(fr, 1'b0);
    end_frame();
    chk("t6_wr_cnt", 32'(wq.size()), 32'h1);
    if (wq.size() > 0) begin
      chk("t6_sel", 32'(wq[0].d), 32'h0);
      chk("t6_wdata", wq[0].w, 32'hDDCCBBAA);
    end
    chk("t6_err_cnt", 32'(n_err - e0), 32'h1);
    chk("t6_done_cnt", 32'(n_done - d0), 32'h0);

    // Reset mid-word, then a clean reload
    fr = '{8'h02, 8'h00, 8'h01, 8'h44, 8'h44, 8'h44, 8'h44, 8'h55, 8'h66};
    send_list(fr, 1'b0);
    wq.delete();
    reset = 1'b0;
    #1;
    chk_reset_vals("t7_async");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("t7_no_strobe", 32'(wq.size()), 32'h0);
    d0 = n_done;
    fr = '{8'h01, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
    send_list(fr, 1'b0);
    end_frame();
    chk("t7_wr_cnt", 32'(wq.size()), 32'h1);
    if (wq.size() > 0) begin
      chk("t7_waddr", 32'(wq[0].a), 32'h0);
      chk("t7_wdata", wq[0].w, 32'h12345678);
    end
    chk("t7_done_cnt", 32'(n_done - d0), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
